// File: rtl/datamem_stall.sv
// Multi-cycle data memory with a stall handshake for the single-cycle datapath.
// IDLE captures a request, BUSY counts LATENCY cycles and commits, DONE pulses ready.
module datamem_stall #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            cap_write;
  logic            cap_rej;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic            req;
  logic            commit;
  logic            unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  // Upper address bits are deliberately dropped so addresses wrap.
  assign unused_addr_bits = ^addr[31:AW+2];

  assign req    = memread | memwrite;
  assign commit = (state == BUSY) && (cnt == '0);

  // ready/err come from registered state only, never from the inputs.
  assign ready = (state == DONE);
  assign err   = (state == DONE) && cap_rej;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        stall     = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        stall     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      cap_write <= 1'b0;
      cap_rej   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            cnt       <= CNT_INIT;
            cap_write <= memwrite;
            cap_rej   <= (addr[1:0] != 2'b00) || (memread && memwrite);
            cap_idx   <= addr[AW+1:2];
            cap_wdata <= wdata;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (cap_rej) begin
            rdata <= '0;
          end else if (!cap_write) begin
            rdata <= mem[cap_idx];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM has no reset; a reset coinciding with the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && cap_write && !cap_rej) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

endmodule

// File: doc/datamem_stall.md
# datamem_stall

Multi-cycle data memory with a stall handshake. It sits directly downstream of the single-cycle datapath: it takes the ALU result as the byte address and `regd2` as write data, and returns load data for the `memtoreg` mux. It replaces the zero-latency data memory with a RAM of configurable access latency. While an access is in flight it drives `stall`, which the top level uses to hold the PC and suppress the register-file write.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; a power of two, at least 2.
- `LATENCY`, default 2: BUSY cycles per access; at least 1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `memread`  in  1  load request; held stable by the datapath while `stall`=1.
- `memwrite`  in  1  store request; held stable while `stall`=1.
- `addr`  in  32  byte address (the ALU output).
- `wdata`  in  32  store data (`regd2`).
- `rdata`  out  32  registered load data.
- `stall`  out  1  access pending; the PC and register file must hold.
- `ready`  out  1  one-cycle pulse when the access completes.
- `err`  out  1  one-cycle pulse with `ready` when the access was rejected.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. The state, a down-counter `cnt` of width clog2(LATENCY)+1, and a captured request (`op`, word index, `wdata`, reject flag) are all registered.
- **IDLE.** A request is present when `memread|memwrite`=1.
  - `stall` = request present. This is combinational from the inputs, so the PC is held in the same cycle.
  - On the clock edge with a request present:
    - capture the request;
    - load `cnt` = LATENCY-1;
    - go to BUSY.
- **Reject conditions.** The request is captured with the reject flag set when either of these holds:
  - `addr[1:0]` != 0 (misaligned);
  - `memread` and `memwrite` are both 1.
  - A rejected request still walks the full BUSY/DONE sequence. No RAM write occurs, and `rdata` is loaded with 0.
- **Word index.** The index is `addr[clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- **BUSY.**
  - `stall`=1.
  - Each edge with `cnt`!=0: decrement `cnt`.
  - Edge with `cnt`==0: commit and go to DONE. For a store, `mem[idx]` <= captured `wdata`. For a load, `rdata` <= `mem[idx]`.
- **DONE.**
  - `stall`=0, `ready`=1, and `err` = reject flag.
  - Inputs are ignored in this cycle.
  - The next edge always goes to IDLE. The datapath advances the PC on that same edge.
- **`rdata` hold rule.** `rdata` holds its value until the next load or rejected commit. A store does not change `rdata`.
- **Reset.** `rst`=1 at an edge forces:
  - state IDLE, `cnt`=0;
  - `rdata`=0, `ready`=0, `err`=0;
  - captured request cleared.
- **RAM contents.** The RAM is not reset. Simulation initialises it to 0.
- **Reset mid-operation.** An access aborted by reset before its commit edge performs no write. If `rst` and a commit coincide on the same edge, reset wins and no write occurs.

## Timing
- An access takes LATENCY+2 cycles in total: 1 IDLE cycle, LATENCY BUSY cycles, and 1 DONE cycle. With the default LATENCY=2 that is 4 cycles.
- `stall` is high for LATENCY+1 consecutive cycles, then low in DONE.
- `ready` is high in exactly one cycle per access, the DONE cycle. `rdata` is valid in that cycle.
- Back-to-back accesses: after DONE, the first IDLE cycle may accept the next request. `stall` is therefore low only in the DONE cycle between two accesses.
- Cycles with no request: `stall`=0, `ready`=0, and the FSM stays in IDLE.
- After reset deassertion: `stall` follows the inputs combinationally; all registered outputs are 0.
- `stall` has no combinational path to `rdata`, `ready` or `err`. Only IDLE `stall` depends combinationally on the inputs.

## Test plan
- **Store then load.** With LATENCY=2: store `wdata`=0xDEADBEEF to `addr`=0x10, then load 0x10.
  - Required: `stall` high for 3 cycles on each access.
  - Required: `ready` pulses in cycles 4 and 8.
  - Required: `rdata`=0xDEADBEEF in cycle 8.
- **Misaligned store.** Store to `addr`=0x12.
  - Required: `ready`=`err`=1 in the DONE cycle.
  - Required: a subsequent load of 0x10 returns the prior value, unchanged.
- **Both requests.** Assert `memread`=`memwrite`=1.
  - Required: `err` pulse, `rdata`=0, and no RAM write.
- **Wrap-around.** With DEPTH_WORDS=1024: store 0x1234 to `addr`=0x0000_1000, then load `addr`=0.
  - Required: the load returns 0x1234.
- **Reset mid-BUSY.** Start a store of 0xA5A5A5A5 to 0x20 and assert `rst` in its second BUSY cycle; then load 0x20.
  - Required: after reset, all outputs are 0 and the FSM is in IDLE.
  - Required: the load returns the old value, not 0xA5A5A5A5.
- **Back-to-back.** With LATENCY=1, issue load/load/store continuously.
  - Required: `stall` pattern 1,1,0 repeating.
  - Required: `ready` high every third cycle.
  - Required: `rdata` updates only on the load completions.
